// File: rtl/ecpri_tx.sv
// eCPRI RMA response transmitter: queues read/write response requests,
// builds the response frame and streams it byte-wise to the egress FIFO.
// Ports: clk, reset (async, active-high); request pulses + sideband
// (send_read_resp, send_write_resp, resp_payload_len, resp_addr, rma_id);
// payload memory (mem_addr, mem_oe, mem_rdata); byte stream (tx_data,
// tx_valid, tx_ready, tx_sop, tx_eop); status (busy, err_overrun).
// Optional: define ECPRI_TX_XOR_EN to append an XOR checksum byte.
module ecpri_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter logic [7:0] ECPRI_REV = 8'h10,
  parameter logic [7:0] MSG_TYPE = 8'h04
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  send_read_resp,
  input  logic                  send_write_resp,
  input  logic [7:0]            resp_payload_len,
  input  logic [ADDR_WIDTH-1:0] resp_addr,
  input  logic [7:0]            rma_id,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_oe,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_sop,
  output logic                  tx_eop,
  output logic                  busy,
  output logic                  err_overrun
);

  typedef enum logic [2:0] {
    IDLE, HDR, RD_REQ, RD_WAIT, DATA, CSUM, DONE
  } state_t;

  state_t state, state_n;

`ifdef ECPRI_TX_XOR_EN
  localparam state_t FIN = CSUM;
  localparam logic XOR_EN = 1'b1;
`else
  localparam state_t FIN = DONE;
  localparam logic XOR_EN = 1'b0;
`endif

  logic                  rd_pend, wr_pend;
  logic [7:0]            rd_len, wr_len;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
  logic [7:0]            rd_id, wr_id;

  logic                  cur_rd;
  logic [7:0]            cur_len;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [7:0]            cur_id;
  logic [3:0]            cnt;
  logic [7:0]            k;
  logic [DATA_WIDTH-1:0] hold;

  logic        ld_rd, ld_wr, rd_take, wr_take;
  logic        xfer, last_hdr, last_data, n_zero;
  logic [7:0]  n_len;
  logic [15:0] psize;
  logic [15:0] addr16;
  logic [7:0]  hdr_byte;

  assign ld_rd = (state == IDLE) && rd_pend;
  assign ld_wr = (state == IDLE) && !rd_pend && wr_pend;
  // A slot being loaded this cycle is free for a new request.
  assign rd_take = send_read_resp && (!rd_pend || ld_rd);
  assign wr_take = send_write_resp && (!wr_pend || ld_wr);

  assign xfer      = tx_valid && tx_ready;
  assign n_len     = cur_rd ? cur_len : 8'd0;
  assign n_zero    = (n_len == 8'd0);
  assign last_hdr  = (cnt == 4'd8);
  assign last_data = ((k + 8'd1) == cur_len);
  assign psize     = {8'd0, n_len} + 16'd5;
  assign addr16    = 16'(cur_addr);
  assign busy      = (state != IDLE) || rd_pend || wr_pend;

  always_comb begin
    hdr_byte = cur_len;
    unique case (cnt)
      4'd0: hdr_byte = ECPRI_REV;
      4'd1: hdr_byte = MSG_TYPE;
      4'd2: hdr_byte = psize[15:8];
      4'd3: hdr_byte = psize[7:0];
      4'd4: hdr_byte = cur_id;
      4'd5: hdr_byte = cur_rd ? 8'h01 : 8'h11;
      4'd6: hdr_byte = addr16[15:8];
      4'd7: hdr_byte = addr16[7:0];
      default: hdr_byte = cur_len;
    endcase
  end

`ifdef ECPRI_TX_XOR_EN
  logic [DATA_WIDTH-1:0] csum;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum <= '0;
    end else if (ld_rd || ld_wr) begin
      csum <= '0;
    end else if (xfer) begin
      csum <= csum ^ tx_data;
    end
  end
`endif

  always_comb begin
    state_n  = state;
    tx_valid = 1'b0;
    tx_data  = '0;
    tx_sop   = 1'b0;
    tx_eop   = 1'b0;
    mem_oe   = 1'b0;
    mem_addr = '0;
    unique case (state)
      IDLE: begin
        if (rd_pend || wr_pend) state_n = HDR;
      end
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = DATA_WIDTH'(hdr_byte);
        tx_sop   = (cnt == 4'd0);
        tx_eop   = last_hdr && n_zero && !XOR_EN;
        if (xfer && last_hdr) state_n = n_zero ? FIN : RD_REQ;
      end
      RD_REQ: begin
        mem_oe   = 1'b1;
        mem_addr = cur_addr + ADDR_WIDTH'(k);
        state_n  = RD_WAIT;
      end
      RD_WAIT: state_n = DATA;
      DATA: begin
        tx_valid = 1'b1;
        tx_data  = hold;
        tx_eop   = last_data && !XOR_EN;
        if (xfer) state_n = last_data ? FIN : RD_REQ;
      end
      CSUM: begin
`ifdef ECPRI_TX_XOR_EN
        tx_valid = 1'b1;
        tx_data  = csum;
        tx_eop   = 1'b1;
        if (xfer) state_n = DONE;
`else
        state_n = DONE;
`endif
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend     <= 1'b0;
      wr_pend     <= 1'b0;
      rd_len      <= '0;
      rd_addr     <= '0;
      rd_id       <= '0;
      wr_len      <= '0;
      wr_addr     <= '0;
      wr_id       <= '0;
      err_overrun <= 1'b0;
    end else begin
      rd_pend <= rd_take || (rd_pend && !ld_rd);
      wr_pend <= wr_take || (wr_pend && !ld_wr);
      if (rd_take) begin
        rd_len  <= resp_payload_len;
        rd_addr <= resp_addr;
        rd_id   <= rma_id;
      end
      if (wr_take) begin
        wr_len  <= resp_payload_len;
        wr_addr <= resp_addr;
        wr_id   <= rma_id;
      end
      if ((send_read_resp && !rd_take) ||
          (send_write_resp && !wr_take))
        err_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_rd   <= 1'b0;
      cur_len  <= '0;
      cur_addr <= '0;
      cur_id   <= '0;
      cnt      <= '0;
      k        <= '0;
      hold     <= '0;
    end else begin
      if (ld_rd) begin
        cur_rd   <= 1'b1;
        cur_len  <= rd_len;
        cur_addr <= rd_addr;
        cur_id   <= rd_id;
      end else if (ld_wr) begin
        cur_rd   <= 1'b0;
        cur_len  <= wr_len;
        cur_addr <= wr_addr;
        cur_id   <= wr_id;
      end
      if (ld_rd || ld_wr)            cnt <= '0;
      else if (state == HDR && xfer) cnt <= cnt + 4'd1;
      if (ld_rd || ld_wr)             k <= '0;
      else if (state == DATA && xfer) k <= k + 8'd1;
      if (state == RD_WAIT) hold <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_ecpri_tx.sv
// Self-checking bench for ecpri_tx: random and directed response requests
// compared against a frame-level reference model.
module tb_ecpri_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        send_read_resp, send_write_resp;
  logic [7:0]  resp_payload_len;
  logic [15:0] resp_addr;
  logic [7:0]  rma_id;
  logic [15:0] mem_addr;
  logic        mem_oe;
  logic [7:0]  mem_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, tx_sop, tx_eop;
  logic        busy, err_overrun;

  int n_chk = 0;
  int n_pass = 0;
  int rdy_mode = 0;
  int n_eop = 0;
  int pos = 0;

  logic [9:0]  got_q[$];
  logic [9:0]  exp_q[$];
  logic [15:0] oe_q[$];
  logic [15:0] exp_oe[$];

  logic        stall_prev = 1'b0;
  logic [10:0] prev_word;

  ecpri_tx dut (
    .clk(clk), .reset(reset),
    .send_read_resp(send_read_resp),
    .send_write_resp(send_write_resp),
    .resp_payload_len(resp_payload_len),
    .resp_addr(resp_addr), .rma_id(rma_id),
    .mem_addr(mem_addr), .mem_oe(mem_oe),
    .mem_rdata(mem_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_sop(tx_sop),
    .tx_eop(tx_eop), .busy(busy),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] memval(logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction

  always @(posedge clk) begin
    if (mem_oe) mem_rdata <= memval(mem_addr);
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
      pos = 0;
    end else begin
      if (stall_prev)
        chk("stall_hold", 32'({tx_valid, tx_sop, tx_eop, tx_data}),
            32'(prev_word));
      if (tx_valid && tx_ready) begin
        got_q.push_back({tx_sop, tx_eop, tx_data});
        if (tx_eop) begin
          n_eop++;
          pos = 0;
        end else begin
          pos++;
        end
      end
      if (mem_oe) oe_q.push_back(mem_addr);
      stall_prev = tx_valid && !tx_ready;
      prev_word = {tx_valid, tx_sop, tx_eop, tx_data};
    end
  end

  task automatic add_frame(bit rd, logic [7:0] id,
                           logic [15:0] addr, logic [7:0] len);
    logic [7:0] b[$];
    int n;
    int sz;
    logic [7:0] x;
    n  = rd ? int'(len) : 0;
    sz = n + 5;
    b.push_back(8'h10);
    b.push_back(8'h04);
    b.push_back(8'(sz / 256));
    b.push_back(8'(sz % 256));
    b.push_back(id);
    b.push_back(rd ? 8'h01 : 8'h11);
    b.push_back(addr[15:8]);
    b.push_back(addr[7:0]);
    b.push_back(len);
    for (int i = 0; i < n; i++) begin
      b.push_back(memval(addr + 16'(i)));
      exp_oe.push_back(addr + 16'(i));
    end
`ifdef ECPRI_TX_XOR_EN
    x = 8'h00;
    foreach (b[i]) x = x ^ b[i];
    b.push_back(x);
`else
    x = 8'h00;
`endif
    foreach (b[i])
      exp_q.push_back({i == 0, i == b.size() - 1, b[i]});
  endtask

  task automatic compare(string tag);
    int m;
    chk($sformatf("%s_nbytes", tag), got_q.size(), exp_q.size());
    m = got_q.size() < exp_q.size() ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    chk($sformatf("%s_noe", tag), oe_q.size(), exp_oe.size());
    m = oe_q.size() < exp_oe.size() ? oe_q.size() : exp_oe.size();
    for (int i = 0; i < m; i++)
      chk($sformatf("%s_oe%0d", tag, i), 32'(oe_q[i]), 32'(exp_oe[i]));
    got_q.delete();
    exp_q.delete();
    oe_q.delete();
    exp_oe.delete();
  endtask

  task automatic pulse(bit rd, bit wr, logic [7:0] id,
                       logic [15:0] addr, logic [7:0] len);
    @(posedge clk);
    #1;
    send_read_resp   = rd;
    send_write_resp  = wr;
    rma_id           = id;
    resp_addr        = addr;
    resp_payload_len = len;
    @(posedge clk);
    #1;
    send_read_resp  = 1'b0;
    send_write_resp = 1'b0;
  endtask

  task automatic wait_idle(string tag);
    int c;
    c = 0;
    while (busy && c < 3000) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk($sformatf("%s_idle", tag), busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run(string tag, bit rd, bit wr, logic [7:0] id,
                     logic [15:0] addr, logic [7:0] len);
    if (rd) add_frame(1'b1, id, addr, len);
    if (wr) add_frame(1'b0, id, addr, len);
    pulse(rd, wr, id, addr, len);
    wait_idle(tag);
    compare(tag);
  endtask

  initial begin
    int e0, c;
    bit rd, wr;
    reset = 1'b1;
    send_read_resp = 1'b0;
    send_write_resp = 1'b0;
    resp_payload_len = '0;
    resp_addr = '0;
    rma_id = '0;
    tx_ready = 1'b1;
    mem_rdata = '0;
    #12;
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_sop_eop", {tx_sop, tx_eop}, 2'b00);
    chk("rst_oe", mem_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_overrun, 1'b0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_maddr", mem_addr, 16'h0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    add_frame(1'b1, 8'h05, 16'h0040, 8'd3);
    pulse(1'b1, 1'b0, 8'h05, 16'h0040, 8'd3);
    chk("lat_busy", busy, 1'b1);
    chk("lat_v0", tx_valid, 1'b0);
    @(posedge clk);
    #1;
    chk("lat_v1", {tx_valid, tx_sop, tx_data}, {2'b11, 8'h10});
    wait_idle("rd");
    compare("rd");

    run("wr", 1'b0, 1'b1, 8'h05, 16'h0100, 8'd4);
    run("both", 1'b1, 1'b1, 8'h33, 16'h1234, 8'd0);
    rdy_mode = 1;
    run("bp", 1'b1, 1'b0, 8'h05, 16'h0040, 8'd3);
    rdy_mode = 2;
    run("wrap", 1'b1, 1'b0, 8'h7E, 16'hFFFE, 8'd4);
    rdy_mode = 0;
    run("len255", 1'b1, 1'b0, 8'hC3, 16'h8000, 8'd255);
    run("w255", 1'b0, 1'b1, 8'h01, 16'hABCD, 8'd255);

    for (int i = 0; i < 25; i++) begin
      rdy_mode = $urandom_range(0, 2);
      c = $urandom_range(0, 2);
      rd = (c != 1);
      wr = (c != 0);
      run($sformatf("rnd%0d", i), rd, wr, 8'($urandom),
          16'($urandom), 8'($urandom_range(0, 12)));
    end
    chk("no_overrun", err_overrun, 1'b0);

    rdy_mode = 0;
    add_frame(1'b1, 8'h21, 16'h0200, 8'd5);
    add_frame(1'b0, 8'h22, 16'h0300, 8'd1);
    pulse(1'b1, 1'b0, 8'h21, 16'h0200, 8'd5);
    pulse(1'b0, 1'b1, 8'h22, 16'h0300, 8'd1);
    chk("ovr_pre", err_overrun, 1'b0);
    pulse(1'b0, 1'b1, 8'h23, 16'h0400, 8'd2);
    chk("ovr_set", err_overrun, 1'b1);
    wait_idle("ovr");
    compare("ovr");
    run("ovr2", 1'b0, 1'b1, 8'h24, 16'h0500, 8'd0);
    chk("ovr_sticky", err_overrun, 1'b1);

    add_frame(1'b0, 8'h31, 16'h5A5A, 8'd2);
    pulse(1'b0, 1'b1, 8'h31, 16'h5A5A, 8'd2);
    e0 = n_eop;
    c = 0;
    do begin
      @(negedge clk);
      #1;
      c++;
    end while (!(pos == 7 && tx_valid) && c < 100);
    chk("rst6_reach", (c < 100), 1'b1);
    chk("rst6_byte", tx_data, 8'h5A);
    reset = 1'b1;
    #1;
    chk("rst6_valid", tx_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    oe_q.delete();
    exp_oe.delete();
    repeat (10) @(posedge clk);
    #1;
    chk("rst6_busy", busy, 1'b0);
    chk("rst6_err", err_overrun, 1'b0);
    chk("rst6_quiet", got_q.size(), 0);
    chk("rst6_noeop", n_eop, e0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ecpri_tx.md
Name: ecpri_tx

Overview:
- eCPRI remote-memory-access (RMA) response transmitter, the counterpart of the eCPRI receive parser.
- Triggered by the parser's single-cycle send_read_resp / send_write_resp pulses; builds the response frame and streams it byte-wise into the egress FIFO.
- For read responses, fetches payload bytes from the shared payload memory.
- Response ID, address and length are captured from the request sideband when each pulse arrives.

Parameters:
DATA_WIDTH, 8, byte-stream and memory data width
ADDR_WIDTH, 16, payload memory address width
ECPRI_REV, 8'h10, eCPRI header byte 0 (revision 1, C=0)
MSG_TYPE, 8'h04, eCPRI message type (remote memory access)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
send_read_resp  in  1  one-cycle pulse: queue read response
send_write_resp  in  1  one-cycle pulse: queue write response
resp_payload_len  in  8  byte count, sampled with the request pulse
resp_addr  in  ADDR_WIDTH  memory address, sampled with the request pulse
rma_id  in  8  RMA ID, sampled with the request pulse
mem_addr  out  ADDR_WIDTH  payload memory read address
mem_oe  out  1  memory read strobe; data valid on mem_rdata 1 clk later
mem_rdata  in  DATA_WIDTH  memory read data
tx_data  out  DATA_WIDTH  egress byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  egress FIFO can accept a byte
tx_sop  out  1  first byte of frame (qualified by tx_valid)
tx_eop  out  1  last byte of frame (qualified by tx_valid)
busy  out  1  frame in progress or request pending
err_overrun  out  1  sticky: request dropped

Behaviour:
- Reset values: tx_valid, tx_sop, tx_eop, mem_oe, busy, err_overrun = 0; tx_data, mem_addr = 0.
- Reset is asynchronous. Asserting it mid-frame drops tx_valid immediately and abandons the frame; no eop is emitted. Pending requests are cleared.
- Byte transfer occurs when tx_valid && tx_ready. While tx_valid && !tx_ready, tx_data, tx_sop and tx_eop hold stable.
- Request capture:
  - There is one pending slot per type (read, write). Each slot holds {len, addr, id}.
  - A pulse arriving while its slot is already full is dropped and sets err_overrun.
  - Pulses are accepted in any state, including in the same cycle as frame completion.
- Arbitration in IDLE: read slot first, then write. If both pulses arrive together, read is sent first and write follows back-to-back.
- Frame layout (byte index: value):
  - 0: ECPRI_REV
  - 1: MSG_TYPE
  - 2-3: payload size, big-endian, = 5 + N
  - 4: rma_id
  - 5: op, 8'h01 for read response, 8'h11 for write response
  - 6-7: addr, big-endian
  - 8: len
  - 9..8+N: data
  - N = len for read responses; N = 0 for write responses.
- Payload size arithmetic: 16-bit, zero-extended len + 5; len 255 gives 16'h0104.
- State machine:
  - IDLE: when a slot is pending, load it, clear the slot, go to HDR. busy = 1.
  - HDR: byte counter 0..8 advances on each transfer. tx_sop is set on byte 0. After byte 8: write response or N = 0 goes to DONE; otherwise go to RD_REQ.
  - RD_REQ: mem_oe = 1 for 1 clk, mem_addr = addr + k (k = data index, 16-bit wrap-around), then go to RD_WAIT.
  - RD_WAIT: capture mem_rdata into the hold register, present it with tx_valid = 1, go to DATA.
  - DATA: on transfer, k++. If k == N, go to DONE; else go to RD_REQ. Throughput is 1 byte per 3 clk minimum.
  - DONE: 1 clk, then IDLE. busy drops only if no slot is pending.
- tx_eop: asserted on the last emitted byte, i.e. byte 8 when N = 0, else the last data byte.
- Header latency: first tx_valid appears 2 clk after the request pulse (capture cycle, then IDLE load).

Optional Feature:
ECPRI_TX_XOR_EN
- Defined:
  - After the final frame byte, a CSUM state appends one byte equal to the XOR of all preceding frame bytes.
  - tx_eop moves to the checksum byte.
  - The payload size field is unchanged.
- Undefined: no CSUM state and no trailing byte.

Test Plan:
- Read: rma_id = 8'h05, addr = 16'h0040, len = 3, mem[40..42] = A1,A2,A3, tx_ready = 1 -> stream 10 04 00 08 05 01 00 40 03 A1 A2 A3. sop on 10, eop on A3. mem_oe pulses at 0040, 0041, 0042.
- Write: rma_id = 8'h05, addr = 16'h0100, len = 4 -> stream 10 04 00 05 05 11 01 00 04, eop on 04, no mem_oe. With ECPRI_TX_XOR_EN an extra byte 00 follows, carrying eop.
- Simultaneous pulses: read (len = 0) and write in the same cycle -> read frame 10 04 00 05 .. 01 .. 00 (eop), then write frame back-to-back. err_overrun stays 0.
- Backpressure: tx_ready toggles 1/0 every clk during the read test -> identical byte sequence, with tx_data stable in every stalled cycle.
- Overrun: two send_write_resp pulses during an active read frame -> first is sent after the read; second sets err_overrun = 1, which persists until reset.
- Reset at header byte 6 -> tx_valid = 0 in the same cycle. After release, the block is idle, busy = 0, and no eop has been observed.
